// File: rtl/gate_arbiter.sv
// gate_arbiter
// Round-robin arbiter for eight parking-lot gates sharing one occupancy
// counter. Each gate raises req[i] with dir[i] (1 = entry, 0 = exit) and
// holds it until it sees grant[i]. A single-cycle grant applies the count
// update. The arbiter then waits for the granted gate to drop its request
// before it arbitrates again.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   req[7:0]  per-gate service request
//   dir[7:0]  per-gate direction, sampled only for the granted gate
//   capacity  lot capacity (N bits, quasi-static)
//   select    index of the current/last granted gate (shared mux select)
//   grant     one-hot grant, high for exactly one cycle per transaction
//   count     current occupancy
//   full      count >= capacity
//   empty     count == 0
//   reject    pulse during a grant whose count update was refused
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate among requests from ptr upward
// GRANT   | one cycle; grant[select] high, count updated at cycle end
// RELEASE | wait for req[select] to drop; other requests are ignored
module gate_arbiter #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   req,
    input  logic [7:0]   dir,
    input  logic [N-1:0] capacity,
    output logic [2:0]   select,
    output logic [7:0]   grant,
    output logic [N-1:0] count,
    output logic         full,
    output logic         empty,
    output logic         reject
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [N-1:0] CNT_ONE = 1;

    state_t       state_q, state_d;
    logic [2:0]   select_q, select_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [N-1:0] count_q, count_d;

    logic         found;
    logic [2:0]   winner;
    logic [2:0]   idx;

    // Round-robin search starting at ptr; the 3-bit index wraps 7 -> 0.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Full is compared against the live capacity, so lowering capacity
    // below the count blocks entries at once without touching the count.
    assign full   = (count_q >= capacity);
    assign empty  = (count_q == '0);
    assign reject = (state_q == GRANT) && (dir[select_q] ? full : empty);
    assign grant  = (state_q == GRANT) ? (8'b1 << select_q) : 8'b0;
    assign select = select_q;
    assign count  = count_q;

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = GRANT;
                    select_d = winner;
                    ptr_d    = winner + 3'd1;
                end
            end
            GRANT: begin
                state_d = RELEASE;
                if (dir[select_q]) begin
                    if (!full) count_d = count_q + CNT_ONE;
                end else begin
                    if (!empty) count_d = count_q - CNT_ONE;
                end
            end
            RELEASE: begin
                if (!req[select_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            select_q <= '0;
            ptr_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_gate_arbiter.sv
module tb_gate_arbiter;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] dir;
    logic [5:0] capacity;
    logic [2:0] select;
    logic [7:0] grant;
    logic [5:0] count;
    logic       full;
    logic       empty;
    logic       reject;

    gate_arbiter #(.N(6)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .dir      (dir),
        .capacity (capacity),
        .select   (select),
        .grant    (grant),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .reject   (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         gate;
        logic       rej;
        logic [5:0] cnt;
    } exp_t;

    typedef struct {
        int         gate;
        logic       d;
        logic [5:0] cap;
        logic       rej;
        logic [5:0] cnt;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic       pend = 1'b0;
    logic [5:0] pend_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every grant pops the next expected transaction;
    // the count is compared on the following cycle, after the update edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("count_after_grant", 32'(count), 32'(pend_cnt));
                pend = 1'b0;
            end
            chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            if (grant == 8'h00) begin
                chk("reject_without_grant", 32'(reject), 32'd0);
            end else if (sb.size() == 0) begin
                chk("unexpected_grant", 32'(grant), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("grant_vector", 32'(grant), 32'(8'b1 << e.gate));
                chk("select", 32'(select), 32'(e.gate));
                chk("reject", 32'(reject), 32'(e.rej));
                pend     = 1'b1;
                pend_cnt = e.cnt;
            end
        end
    end

    task automatic wait_grant(output logic [7:0] g);
        g = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant != 8'h00) begin
                g = grant;
                return;
            end
        end
        chk("grant_timeout", 32'd0, 32'd1);
    endtask

    // One complete single-gate transaction, driven from a negedge.
    task automatic txn(input int gate, input logic d, input logic rej, input logic [5:0] cnt);
        exp_t       e;
        logic [7:0] g;
        e.gate = gate;
        e.rej  = rej;
        e.cnt  = cnt;
        sb.push_back(e);
        dir[gate] = d;
        req[gate] = 1'b1;
        wait_grant(g);
        req[gate] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    vec_t       tbl[9];
    logic [5:0] model_cnt;
    logic [7:0] g;
    exp_t       e;

    initial begin
        tbl[0] = '{gate: 2, d: 1'b1, cap: 6'd3, rej: 1'b0, cnt: 6'd1};
        tbl[1] = '{gate: 5, d: 1'b1, cap: 6'd2, rej: 1'b0, cnt: 6'd2};
        tbl[2] = '{gate: 5, d: 1'b1, cap: 6'd2, rej: 1'b1, cnt: 6'd2};
        tbl[3] = '{gate: 7, d: 1'b0, cap: 6'd2, rej: 1'b0, cnt: 6'd1};
        tbl[4] = '{gate: 7, d: 1'b0, cap: 6'd2, rej: 1'b0, cnt: 6'd0};
        tbl[5] = '{gate: 7, d: 1'b0, cap: 6'd2, rej: 1'b1, cnt: 6'd0};
        tbl[6] = '{gate: 7, d: 1'b1, cap: 6'd2, rej: 1'b0, cnt: 6'd1};
        tbl[7] = '{gate: 0, d: 1'b1, cap: 6'd0, rej: 1'b1, cnt: 6'd1};
        tbl[8] = '{gate: 1, d: 1'b0, cap: 6'd0, rej: 1'b0, cnt: 6'd0};

        reset_n  = 1'b1;
        req      = 8'h00;
        dir      = 8'h00;
        capacity = 6'd3;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_reject", 32'(reject), 32'd0);
        capacity = 6'd0;
        #1 chk("rst_full_cap0", 32'(full), 32'd1);
        capacity = 6'd3;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven single-gate transactions.
        model_cnt = 6'd0;
        for (int i = 0; i < 9; i++) begin
            capacity = tbl[i].cap;
            #1 chk("full_on_cap_change", 32'(full), 32'(model_cnt >= tbl[i].cap));
            txn(tbl[i].gate, tbl[i].d, tbl[i].rej, tbl[i].cnt);
            model_cnt = tbl[i].cnt;
            chk("full_after_txn", 32'(full), 32'(tbl[i].cnt >= tbl[i].cap));
            chk("empty_after_txn", 32'(empty), 32'(tbl[i].cnt == 6'd0));
            chk("idle_grant", 32'(grant), 32'd0);
        end

        // Round robin with all gates requesting: 0..7 then wrap to 0.
        do_reset();
        capacity = 6'd63;
        dir      = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            e.gate = i % 8;
            e.rej  = 1'b0;
            e.cnt  = 6'(i + 1);
            sb.push_back(e);
        end
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            wait_grant(g);
            req = req & ~g;
            repeat (2) @(negedge clk);
            if (i < 8) req = req | g;
        end
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Hold-off: gate 3 keeps req high; gates 1 and 4 wait, 4 wins next.
        dir = 8'h00;
        e = '{gate: 3, rej: 1'b0, cnt: 6'd8};
        sb.push_back(e);
        e = '{gate: 4, rej: 1'b0, cnt: 6'd7};
        sb.push_back(e);
        e = '{gate: 1, rej: 1'b0, cnt: 6'd6};
        sb.push_back(e);
        req[3] = 1'b1;
        wait_grant(g);
        @(negedge clk);
        req[1] = 1'b1;
        req[4] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("holdoff_no_grant", 32'(grant), 32'd0);
        end
        req[3] = 1'b0;
        wait_grant(g);
        req[4] = 1'b0;
        wait_grant(g);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("holdoff_count", 32'(count), 32'd6);

        // Reset in the middle of a GRANT cycle aborts the increment.
        do_reset();
        capacity = 6'd63;
        for (int i = 0; i < 4; i++) txn(6, 1'b1, 1'b0, 6'(i + 1));
        chk("pre_abort_count", 32'(count), 32'd4);
        e = '{gate: 6, rej: 1'b0, cnt: 6'd5};
        sb.push_back(e);
        dir[6] = 1'b1;
        req[6] = 1'b1;
        wait_grant(g);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_select", 32'(select), 32'd0);
        chk("abort_empty", 32'(empty), 32'd1);
        chk("abort_reject", 32'(reject), 32'd0);
        req[6] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_late_inc", 32'(count), 32'd0);
        txn(6, 1'b1, 1'b0, 6'd1);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
